// File: rtl/load_store_unit.sv
// load_store_unit: single req/ack data-memory access stage with byte-lane alignment,
// load extension, misalignment/illegal-op detection and request timeout.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        flag_error,
    output logic        flag_timeout
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wdata, sh, ext;
    always_comb begin
        bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3[2]) ||
              (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        be = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
             funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = !is_store ? 32'h0 :
                funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
        // halfwords are aligned, so a byte-offset shift also covers the 16*addr[1] case
        sh = mem_rdata >> {off, 3'b000};
        ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
              f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : sh;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            off          <= '0;
            f3           <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            load_data    <= '0;
            done         <= 1'b0;
            flag_error   <= 1'b0;
            flag_timeout <= 1'b0;
        end else begin
            done         <= 1'b0;
            flag_error   <= 1'b0;
            flag_timeout <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (bad) begin
                        state      <= ERR;
                        done       <= 1'b1;
                        flag_error <= 1'b1;
                    end else begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= wdata;
                        mem_be    <= be;
                        off       <= addr[1:0];
                        f3        <= funct3;
                    end
                end
                REQ: if (mem_ack || cnt == 8'(TIMEOUT - 1)) begin
                    state        <= DONE;
                    done         <= 1'b1;
                    flag_timeout <= !mem_ack;
                    cnt          <= '0;
                    mem_req      <= 1'b0;
                    mem_we       <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                    mem_be       <= '0;
                    if (mem_ack && !mem_we) load_data <= ext;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
    logic        mem_req, mem_we, done, busy, flag_error, flag_timeout;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] addr, wdata, ld;
        logic [3:0]  be;
        logic        we, err, to;
        int          lat, reqs;
    } exp_t;
    exp_t q[$];

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .load_data(load_data), .done(done), .busy(busy),
        .flag_error(flag_error), .flag_timeout(flag_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ack_at: index of the request cycle carrying mem_ack (-1 = never ack)
    task automatic run(input logic st, input logic [2:0] f, input logic [31:0] a, sd, rd,
                       input int ack_at, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, e_ld, input logic e_err, e_to,
                       input int e_lat, e_reqs);
        exp_t e;
        int lat, reqs;
        q.push_back('{addr: e_addr, wdata: e_wdata, ld: e_ld, be: e_be, we: st,
                      err: e_err, to: e_to, lat: e_lat, reqs: e_reqs});
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f; addr = a; store_data = sd; mem_rdata = rd;
        @(negedge clk);
        start = 1'b0; lat = 1; reqs = 0;
        while (!done && lat < 20) begin
            chk("busy_active", 32'(busy), 32'd1);
            if (mem_req) begin
                if (reqs == 0) begin
                    chk("mem_addr", mem_addr, q[0].addr);
                    chk("mem_be", 32'(mem_be), 32'(q[0].be));
                    chk("mem_we", 32'(mem_we), 32'(q[0].we));
                    chk("mem_wdata", mem_wdata, q[0].wdata);
                end
                mem_ack = (reqs == ack_at);
                reqs++;
            end else mem_ack = 1'b0;
            @(negedge clk);
            lat++;
        end
        mem_ack = 1'b0;
        e = q.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("req_cycles", 32'(reqs), 32'(e.reqs));
        chk("busy_done", 32'(busy), 32'd1);
        chk("req_in_done", 32'(mem_req), 32'd0);
        chk("flag_error", 32'(flag_error), 32'(e.err));
        chk("flag_timeout", 32'(flag_timeout), 32'(e.to));
        chk("load_data", load_data, e.ld);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, 32'h100, 4'hF, 0, 32'hDEADBEEF, 0, 0, 4, 3);
        run(0, 3'b000, 32'h203, 0, 32'h80123456, 0, 32'h200, 4'h8, 0, 32'hFFFFFF80, 0, 0, 2, 1);
        run(0, 3'b100, 32'h203, 0, 32'h80123456, 0, 32'h200, 4'h8, 0, 32'h00000080, 0, 0, 2, 1);
        run(1, 3'b001, 32'h1002, 32'h0000ABCD, 32'h55555555, 0, 32'h1000, 4'hC, 32'hABCDABCD,
            32'h00000080, 0, 0, 2, 1);
        run(0, 3'b001, 32'h202, 0, 32'h80017FFF, 1, 32'h200, 4'hC, 0, 32'hFFFF8001, 0, 0, 3, 2);
        run(0, 3'b101, 32'h200, 0, 32'h80017FFF, 0, 32'h200, 4'h3, 0, 32'h00007FFF, 0, 0, 2, 1);
        run(1, 3'b000, 32'h1001, 32'h1234565A, 0, 0, 32'h1000, 4'h2, 32'h5A5A5A5A,
            32'h00007FFF, 0, 0, 2, 1);
        run(0, 3'b010, 32'h102, 0, 0, 0, 0, 4'h0, 0, 32'h00007FFF, 1, 0, 1, 0);
        run(1, 3'b100, 32'h100, 32'hFF, 0, 0, 0, 4'h0, 0, 32'h00007FFF, 1, 0, 1, 0);
        run(0, 3'b111, 32'h100, 0, 0, 0, 0, 4'h0, 0, 32'h00007FFF, 1, 0, 1, 0);
        run(0, 3'b010, 32'h300, 0, 32'h99999999, -1, 32'h300, 4'hF, 0, 32'h00007FFF, 0, 1, 5, 4);
        run(0, 3'b010, 32'h304, 0, 32'h11223344, 3, 32'h304, 4'hF, 0, 32'h11223344, 0, 0, 5, 4);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_load_data", load_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run(0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 1, 32'h400, 4'hF, 0, 32'hCAFEF00D, 0, 0, 3, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage placed directly downstream of the extended ALU.
- Consumes the ALU result as the effective address and RS2 data as the store data.
- Runs a single req/ack transaction per instruction with data memory: byte-lane alignment on stores, sign/zero extension on loads, misalignment and timeout detection.
- Asserts busy so the pipeline control stalls the EX stage until the access completes.

Parameters:
TIMEOUT, 64, cycles mem_req may stay high without mem_ack before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  memory instruction valid from EX; sampled only in IDLE
is_store  in  1  1 = store, 0 = load
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
addr  in  32  effective address (ALU Resultado)
store_data  in  32  RS2 data
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  write enable, valid while mem_req
mem_addr  out  32  word address: {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  memory completion, single-cycle
load_data  out  32  extended load result
done  out  1  one-cycle completion pulse
busy  out  1  high whenever state != IDLE
flag_error  out  1  misaligned or illegal op; valid with done
flag_timeout  out  1  access aborted by timeout; valid with done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0, including load_data and the timeout counter.
  - mem_req drops immediately, even mid-transaction.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - start=1 with legal, aligned op: latch addr, funct3, is_store, store_data; go to REQ.
  - start=1 with illegal or misaligned op: go to ERR; mem_req is never raised.
- Illegal op:
  - funct3 in {011,110,111};
  - a store with funct3 in {100,101}.
- Misaligned:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=00.
- REQ:
  - mem_req=1 and all mem_* outputs held stable every cycle.
  - Counter increments each cycle without ack.
  - mem_ack=1: capture the extended mem_rdata (loads only), clear counter, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, set flag_timeout, go to DONE.
  - Ack arriving in the same cycle as the timeout: ack wins, no timeout.
- DONE: done=1 for one cycle, then IDLE. flag_timeout is visible only during this cycle.
- ERR: done=1 and flag_error=1 for one cycle, then IDLE.
- Latency:
  - start sampled at cycle t; mem_req high from t+1.
  - Ack sampled at cycle t+k puts done at t+k+1.
  - Minimum back-to-back period: 3 cycles.
  - Error path: done at t+1.
- start while busy=1 is ignored; upstream must hold the instruction while busy.
- Store lanes (o = addr[1:0]):
  - B: be=1<<o; wdata = byte replicated ×4.
  - H: be=0011 (addr[1]=0) or 1100; wdata = halfword replicated ×2.
  - W: be=1111; wdata = store_data.
- Loads:
  - mem_we=0, mem_wdata=0, be by size as for stores.
  - Result = mem_rdata >> 8*o (H uses 16*addr[1]).
  - Sign-extend for B/H; zero-extend for BU/HU.
- load_data holds the last completed load.
  - Unchanged by stores, errors and timeouts.
  - A timed-out load leaves it unchanged.
- All mem_* outputs return to 0 in IDLE/DONE/ERR.

Test Plan:
1. LW addr=0x100, ack after 2 wait cycles with rdata=0xDEADBEEF:
   - mem_addr=0x100, be=1111, we=0;
   - done 4 cycles after start; load_data=0xDEADBEEF; no flags.
2. LB then LBU at addr=0x203, rdata=0x80123456:
   - LB gives load_data=0xFFFFFF80;
   - LBU gives 0x00000080; be=1000 both times.
3. SH addr=0x1002, store_data=0x0000ABCD, immediate ack:
   - mem_addr=0x1000, be=1100, we=1, wdata=0xABCDABCD;
   - done; load_data unchanged.
4. LW addr=0x102, and separately SB with funct3=100:
   - no mem_req;
   - done+flag_error at t+1; busy high one cycle.
5. TIMEOUT=4, LW with no ack:
   - mem_req high exactly 4 cycles, then done+flag_timeout; load_data unchanged.
   - Repeat with ack on the 4th cycle: normal completion, no flag.
6. rst_n low for 1 cycle while in REQ:
   - mem_req, busy, done go 0 without a clock edge;
   - a new LW after reset completes normally.
